// File: rtl/ps2_byte_receiver.sv
// Receive-only PS/2 device-to-host byte receiver with ps2_clk glitch filter and frame timeout.
// Optional feature macro: PS2_PARITY_CHECK_EN (odd-parity checking; parity_error tied low otherwise).
module ps2_byte_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_signal,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [0:0]  ST_IDLE    = 1'b0;
  localparam logic [0:0]  ST_RECEIVE = 1'b1;
  localparam logic [7:0]  FILT_LAST  = 8'(FILTER_LEN - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

`ifdef PS2_PARITY_CHECK_EN
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    odd_parity_ok = ^{data, par};
  endfunction
`endif

  logic        clk_meta_q, clk_sync_q;
  logic        dat_meta_q, dat_sync_q;
  logic        filt_q, filt_d;
  logic [7:0]  filt_cnt_q, filt_cnt_d;
  logic        filt_dly_q;
  logic        fall_s, fall_q;

  logic [0:0]  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        dv_q, dv_d;
  logic        pe_q, pe_d;
  logic        fe_q, fe_d;
  logic        busy_q, busy_d;
`ifdef PS2_PARITY_CHECK_EN
  logic        parity_q, parity_d;
`endif

  // Two-flop synchronizers for both raw PS/2 lines; idle level is high.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Filtered level only follows the input after FILTER_LEN consecutive differing cycles.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = 8'd0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d     = clk_sync_q;
        filt_cnt_d = 8'd0;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end else begin
      filt_cnt_d = 8'd0;
    end
  end

  assign fall_s = filt_dly_q & ~filt_q;

  // Filter state and the registered falling-edge flag.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= 8'd0;
      filt_dly_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      filt_dly_q <= filt_q;
      fall_q     <= fall_s;
    end
  end

  // Frame FSM: start detection, bit shifting, end-of-frame checks, timeout abort.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    fe_d      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tmo_d = 16'd0;
        if (fall_q && !dat_sync_q) begin
          state_d   = ST_RECEIVE;
          bit_cnt_d = 4'd1;
          shift_d   = 8'h00;
`ifdef PS2_PARITY_CHECK_EN
          parity_d  = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECEIVE: begin
        // A falling edge wins over a simultaneous timeout.
        if (fall_q) begin
          tmo_d     = 16'd0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8) begin
            shift_d = {dat_sync_q, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
            parity_d = dat_sync_q;
`endif
          end else begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            if (!dat_sync_q) begin
              fe_d = 1'b1;
            end
`ifdef PS2_PARITY_CHECK_EN
            else if (!odd_parity_ok(shift_q, parity_q)) begin
              pe_d = 1'b1;
            end
`endif
            else begin
              dv_d   = 1'b1;
              data_d = shift_q;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          fe_d      = 1'b1;
          state_d   = ST_IDLE;
          tmo_d     = 16'd0;
          bit_cnt_d = 4'd0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 4'd0;
        tmo_d     = 16'd0;
      end
    endcase
    busy_d = (state_d == ST_RECEIVE);
  end

  // FSM and output registers.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      tmo_q     <= 16'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      busy_q    <= busy_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign data_out     = data_q;
  assign data_valid   = dv_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Directed self-checking bench for ps2_byte_receiver (short timeout and half-periods for run time).
module tb_ps2_byte_receiver;

  localparam int FL   = 8;
  localparam int TMO  = 300;
  localparam int HALF = 50;
  localparam int LAT  = FL + 3;

  logic       clock = 1'b0;
  logic       reset_signal;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_cnt = 0, pe_cnt = 0, fe_cnt = 0, busy_cnt = 0, multi_cnt = 0;
  int dv_cyc = 0, pe_cyc = 0, fe_cyc = 0;
  int last_fall_cyc = 0;

  ps2_byte_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_signal(reset_signal), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data_out(data_out), .data_valid(data_valid), .parity_error(parity_error),
    .frame_error(frame_error), .busy(busy)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor: counts high cycles of each strobe and records when they occur.
  always @(negedge clock) begin
    if (data_valid)   begin dv_cnt++; dv_cyc = cyc; end
    if (parity_error) begin pe_cnt++; pe_cyc = cyc; end
    if (frame_error)  begin fe_cnt++; fe_cyc = cyc; end
    if (busy) busy_cnt++;
    if (int'(data_valid) + int'(parity_error) + int'(frame_error) > 1) multi_cnt++;
  end

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  // Sends frame bits fr[0..n-1]; last_fall_cyc is the cycle index of the edge sampling each raw fall.
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ps2_data = fr[i];
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc + 1;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bits({stop, par, d, 1'b0}, 11);
    repeat (HALF) @(negedge clock);
    ps2_data = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    reset_signal = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clock);
    settle();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    checks++; if ({data_valid, parity_error, frame_error, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {data_valid, parity_error, frame_error, busy});
    end
    @(negedge clock);
    reset_signal = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_good_frame();
    int dv0 = dv_cnt, pe0 = pe_cnt, fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL good_dv_count: got %0d expected 1", dv_cnt - dv0); end
    checks++; if (data_out !== 8'h1C) begin errors++; $display("FAIL good_data: got %h expected 1c", data_out); end
    checks++; if (dv_cyc !== last_fall_cyc + LAT) begin
      errors++; $display("FAIL good_latency: got %0d expected %0d", dv_cyc - last_fall_cyc, LAT);
    end
    checks++; if ((pe_cnt - pe0) + (fe_cnt - fe0) !== 0) begin
      errors++; $display("FAIL good_no_error: got %0d expected 0", (pe_cnt - pe0) + (fe_cnt - fe0));
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int dv0 = dv_cnt;
    send_frame(8'hF0, 1'b1, 1'b1);
    checks++; if (data_out !== 8'hF0) begin errors++; $display("FAIL b2b_first_data: got %h expected f0", data_out); end
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (data_out !== 8'h1C) begin errors++; $display("FAIL b2b_second_data: got %h expected 1c", data_out); end
    checks++; if (dv_cnt - dv0 !== 2) begin errors++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_cnt - dv0); end
  endtask

  task automatic test_timeout();
    int dv0 = dv_cnt, fe0 = fe_cnt;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_busy_mid: got %b expected 1", busy); end
    repeat (HALF) @(negedge clock);
    ps2_data = 1'b1;
    repeat (TMO + 40) @(negedge clock);
    settle();
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL tmo_fe_count: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (fe_cyc !== last_fall_cyc + LAT + TMO) begin
      errors++; $display("FAIL tmo_timing: got %0d expected %0d", fe_cyc - last_fall_cyc - LAT, TMO);
    end
    checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL tmo_no_dv: got %0d expected %0d", dv_cnt, dv0); end
    checks++; if (data_out !== 8'h1C) begin errors++; $display("FAIL tmo_data_hold: got %h expected 1c", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy_after: got %b expected 0", busy); end
    send_frame(8'h29, 1'b0, 1'b1);
    checks++; if (data_out !== 8'h29) begin errors++; $display("FAIL tmo_next_data: got %h expected 29", data_out); end
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL tmo_next_dv: got %0d expected 1", dv_cnt - dv0); end
  endtask

  task automatic test_bad_parity();
    int dv0 = dv_cnt, pe0 = pe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL par_pe_count: got %0d expected 1", pe_cnt - pe0); end
    checks++; if (pe_cyc !== last_fall_cyc + LAT) begin
      errors++; $display("FAIL par_latency: got %0d expected %0d", pe_cyc - last_fall_cyc, LAT);
    end
    checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL par_no_dv: got %0d expected %0d", dv_cnt, dv0); end
    checks++; if (data_out !== 8'h29) begin errors++; $display("FAIL par_data_hold: got %h expected 29", data_out); end
`else
    checks++; if (pe_cnt !== pe0) begin errors++; $display("FAIL par_pe_tied: got %0d expected %0d", pe_cnt, pe0); end
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL par_dv_count: got %0d expected 1", dv_cnt - dv0); end
    checks++; if (data_out !== 8'h1C) begin errors++; $display("FAIL par_data: got %h expected 1c", data_out); end
`endif
  endtask

  task automatic test_bad_stop();
    int dv0 = dv_cnt, fe0 = fe_cnt;
    logic [7:0] prev;
`ifdef PS2_PARITY_CHECK_EN
    prev = 8'h29;
`else
    prev = 8'h1C;
`endif
    send_frame(8'hF0, 1'b1, 1'b0);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL stop_fe_count: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (fe_cyc !== last_fall_cyc + LAT) begin
      errors++; $display("FAIL stop_latency: got %0d expected %0d", fe_cyc - last_fall_cyc, LAT);
    end
    checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL stop_no_dv: got %0d expected %0d", dv_cnt, dv0); end
    checks++; if (data_out !== prev) begin errors++; $display("FAIL stop_data_hold: got %h expected %h", data_out, prev); end
  endtask

  task automatic test_glitch();
    int b0 = busy_cnt, s0 = dv_cnt + pe_cnt + fe_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      ps2_data = i[0];
      ps2_clk = 1'b0;
      repeat (3) @(negedge clock);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clock);
    end
    ps2_data = 1'b1;
    repeat (20) @(negedge clock);
    settle();
    checks++; if (busy_cnt !== b0) begin errors++; $display("FAIL glitch_busy: got %0d expected %0d", busy_cnt, b0); end
    checks++; if (dv_cnt + pe_cnt + fe_cnt !== s0) begin
      errors++; $display("FAIL glitch_strobes: got %0d expected %0d", dv_cnt + pe_cnt + fe_cnt, s0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dv0, e0;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6);
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b expected 1", busy); end
    @(negedge clock);
    reset_signal = 1'b1;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", data_out); end
    checks++; if ({data_valid, parity_error, frame_error, busy} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_flags: got %b expected 0000", {data_valid, parity_error, frame_error, busy});
    end
    repeat (5) @(negedge clock);
    reset_signal = 1'b0;
    repeat (20) @(negedge clock);
    dv0 = dv_cnt;
    e0 = pe_cnt + fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL rst_next_dv: got %0d expected 1", dv_cnt - dv0); end
    checks++; if (data_out !== 8'h1C) begin errors++; $display("FAIL rst_next_data: got %h expected 1c", data_out); end
    checks++; if (pe_cnt + fe_cnt !== e0) begin errors++; $display("FAIL rst_next_err: got %0d expected %0d", pe_cnt + fe_cnt, e0); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_timeout();
    test_bad_parity();
    test_bad_stop();
    test_glitch();
    test_reset_mid_frame();
    checks++; if (multi_cnt !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d expected 0", multi_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
